// File: rtl/clock_pkg.sv
// Shared definitions for the clock/calendar bus masters: year limits and the
// master state encoding.
package clock_pkg;

    localparam int YEAR_WIDTH  = 6;
    localparam int YEAR_MIN    = 1;
    localparam int YEAR_MAX    = 60;
    localparam int LOAD_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

endpackage

// File: rtl/year_bus_master_if.sv
// Read/write bus between a calendar-field master and its value register.
interface year_bus_master_if #(
    parameter int WIDTH = clock_pkg::YEAR_WIDTH
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] databus;

    modport master (output enable, output load, output data, input databus);
    modport slave  (input enable, input load, input data, output databus);
endinterface

// File: rtl/bin2bcd_6.sv
// Combinational 6-bit binary (0..63) to two-digit BCD converter.
module bin2bcd_6 (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [5:0] rem_s;
    logic [3:0] tens_s;

    // Strip tens one at a time; six stages cover the full 0..63 range.
    always_comb begin
        rem_s  = bin;
        tens_s = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem_s >= 6'd10) begin
                rem_s  = rem_s - 6'd10;
                tens_s = tens_s + 4'd1;
            end else begin
                tens_s = tens_s;
            end
        end
    end

    assign tens = tens_s;
    assign ones = rem_s[3:0];

endmodule

// File: rtl/year_bus_master_chk.sv
// Protocol checks for the year bus master.
module year_bus_master_chk (
    input logic clk,
    input logic rst_n,
    input logic enable,
    input logic load
);

    // Read enable and write strobe must never overlap on the register bus.
    a_no_rw_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(enable && load));

endmodule

// File: rtl/year_bus_master.sv
// Year register bus master: continuous read/display in RUN, button-driven
// editing and a timed load strobe to write the new value back.
module year_bus_master
    import clock_pkg::*;
#(
    parameter int WIDTH       = YEAR_WIDTH,
    parameter int MIN_VAL     = YEAR_MIN,
    parameter int MAX_VAL     = YEAR_MAX,
    parameter int LOAD_CYCLES = 1
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                set_btn,
    input  logic                inc_btn,
    input  logic                dec_btn,
    year_bus_master_if.master   bus,
    output logic [3:0]          digit_tens,
    output logic [3:0]          digit_ones,
    output logic                editing
);

    localparam logic [WIDTH-1:0]      MIN_V    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0]      MAX_V    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]      ONE_V    = WIDTH'(1);
    localparam logic [LOAD_CNT_W-1:0] CNT_LAST = LOAD_CNT_W'(LOAD_CYCLES - 1);

    state_e                  state_r;
    logic [LOAD_CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]        shadow_r;
    logic [WIDTH-1:0]        disp_val_r;
    logic [WIDTH-1:0]        data_r;
    logic                    enable_r;
    logic                    load_r;
    logic                    editing_r;
    logic                    set_q_r;
    logic                    inc_q_r;
    logic                    dec_q_r;

    logic                    set_edge_s;
    logic                    inc_edge_s;
    logic                    dec_edge_s;
    logic                    in_range_s;
    logic [WIDTH-1:0]        shadow_nxt_s;

    assign set_edge_s = set_btn & ~set_q_r;
    assign inc_edge_s = inc_btn & ~inc_q_r;
    assign dec_edge_s = dec_btn & ~dec_q_r;
    assign in_range_s = (bus.databus >= MIN_V) && (bus.databus <= MAX_V);

    // Wrapping shadow adjust; simultaneous inc and dec cancel out.
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (inc_edge_s && !dec_edge_s) begin
            shadow_nxt_s = (shadow_r == MAX_V) ? MIN_V : (shadow_r + ONE_V);
        end else if (dec_edge_s && !inc_edge_s) begin
            shadow_nxt_s = (shadow_r == MIN_V) ? MAX_V : (shadow_r - ONE_V);
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Mode FSM with bus strobes registered alongside the state they belong to.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r    <= ST_RUN;
            cnt_r      <= '0;
            shadow_r   <= MIN_V;
            disp_val_r <= MIN_V;
            data_r     <= MIN_V;
            enable_r   <= 1'b0;
            load_r     <= 1'b0;
            editing_r  <= 1'b0;
            set_q_r    <= 1'b0;
            inc_q_r    <= 1'b0;
            dec_q_r    <= 1'b0;
        end else begin
            set_q_r <= set_btn;
            inc_q_r <= inc_btn;
            dec_q_r <= dec_btn;
            case (state_r)
                ST_RUN: begin
                    load_r <= 1'b0;
                    if (set_edge_s) begin
                        shadow_r  <= disp_val_r;
                        state_r   <= ST_EDIT;
                        enable_r  <= 1'b0;
                        editing_r <= 1'b1;
                    end else begin
                        enable_r  <= 1'b1;
                        editing_r <= 1'b0;
                        // Bus data is only trusted once enable has been seen by the register.
                        if (enable_r && in_range_s) begin
                            disp_val_r <= bus.databus;
                        end else begin
                            disp_val_r <= disp_val_r;
                        end
                    end
                end
                ST_EDIT: begin
                    enable_r  <= 1'b0;
                    editing_r <= 1'b1;
                    if (set_edge_s) begin
                        state_r <= ST_COMMIT;
                        cnt_r   <= '0;
                        load_r  <= 1'b1;
                        data_r  <= shadow_r;
                    end else begin
                        load_r     <= 1'b0;
                        shadow_r   <= shadow_nxt_s;
                        disp_val_r <= shadow_nxt_s;
                    end
                end
                ST_COMMIT: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r   <= ST_SETTLE;
                        load_r    <= 1'b0;
                        enable_r  <= 1'b1;
                        editing_r <= 1'b0;
                    end else begin
                        cnt_r     <= cnt_r + LOAD_CNT_W'(1);
                        load_r    <= 1'b1;
                        enable_r  <= 1'b0;
                        editing_r <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    state_r   <= ST_RUN;
                    enable_r  <= 1'b1;
                    load_r    <= 1'b0;
                    editing_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_RUN;
                    enable_r  <= 1'b0;
                    load_r    <= 1'b0;
                    editing_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.enable = enable_r;
    assign bus.load   = load_r;
    assign bus.data   = data_r;
    assign editing    = editing_r;

    bin2bcd_6 u_bcd (
        .bin  (disp_val_r),
        .tens (digit_tens),
        .ones (digit_ones)
    );

    year_bus_master_chk u_chk (
        .clk    (clk),
        .rst_n  (clear_n),
        .enable (enable_r),
        .load   (load_r)
    );

endmodule

// File: tb/tb_year_bus_master.sv
// Directed bench for year_bus_master: two instances (1- and 3-cycle load)
// share all inputs so they run in lockstep except for the write length.
module tb_year_bus_master;

    logic       clk;
    logic       clear_n;
    logic       set_btn;
    logic       inc_btn;
    logic       dec_btn;
    logic [5:0] databus_v;
    logic [3:0] t1, o1, t3, o3;
    logic       ed1, ed3;
    int         total;
    int         bad;

    year_bus_master_if #(.WIDTH(6)) bus1 ();
    year_bus_master_if #(.WIDTH(6)) bus3 ();
    assign bus1.databus = databus_v;
    assign bus3.databus = databus_v;

    year_bus_master #(.WIDTH(6), .MIN_VAL(1), .MAX_VAL(60), .LOAD_CYCLES(1)) dut1 (
        .clk(clk), .clear_n(clear_n), .set_btn(set_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .bus(bus1.master), .digit_tens(t1), .digit_ones(o1), .editing(ed1));

    year_bus_master #(.WIDTH(6), .MIN_VAL(1), .MAX_VAL(60), .LOAD_CYCLES(3)) dut3 (
        .clk(clk), .clear_n(clear_n), .set_btn(set_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .bus(bus3.master), .digit_tens(t3), .digit_ones(o3), .editing(ed3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            0:       set_btn = 1'b1;
            1:       inc_btn = 1'b1;
            default: dec_btn = 1'b1;
        endcase
        step(1);
        set_btn = 1'b0;
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        clear_n = 1'b1; set_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0; databus_v = 6'd23;
        #1 clear_n = 1'b0;
        step(2);
        total++; if (bus1.enable !== 1'b0) begin bad++; $display("FAIL reset_enable got=%0d want=0", bus1.enable); end
        total++; if (bus1.load !== 1'b0) begin bad++; $display("FAIL reset_load got=%0d want=0", bus1.load); end
        total++; if (bus1.data !== 6'd1) begin bad++; $display("FAIL reset_data got=%0d want=1", bus1.data); end
        total++; if ({t1, o1} !== 8'h01) begin bad++; $display("FAIL reset_digits got=%h want=01", {t1, o1}); end
        total++; if (ed1 !== 1'b0) begin bad++; $display("FAIL reset_editing got=%0d want=0", ed1); end
        clear_n = 1'b1;
        step(1);
        total++; if (bus1.enable !== 1'b1) begin bad++; $display("FAIL run_enable got=%0d want=1", bus1.enable); end
        step(1);
        total++; if ({t1, o1} !== 8'h23) begin bad++; $display("FAIL run_digits got=%h want=23", {t1, o1}); end
        total++; if (bus1.load !== 1'b0) begin bad++; $display("FAIL run_load got=%0d want=0", bus1.load); end
        total++; if (ed1 !== 1'b0) begin bad++; $display("FAIL run_editing got=%0d want=0", ed1); end
    endtask

    // Press set from EDIT, then watch six cycles of the write on both instances.
    task automatic do_commit(input logic [5:0] val, input logic [7:0] bcd);
        int n1;
        int n3;
        n1 = 0;
        n3 = 0;
        set_btn = 1'b1;
        step(1);
        total++; if ({bus1.load, bus3.load, ed1, bus1.enable} !== 4'b1110) begin
            bad++; $display("FAIL commit_start got=%b want=1110", {bus1.load, bus3.load, ed1, bus1.enable}); end
        for (int i = 0; i < 6; i++) begin
            if (bus1.load) begin
                n1++;
                total++; if (bus1.data !== val) begin bad++; $display("FAIL commit_data1 got=%0d want=%0d", bus1.data, val); end
            end
            if (bus3.load) begin
                n3++;
                total++; if (bus3.data !== val) begin bad++; $display("FAIL commit_data3 got=%0d want=%0d", bus3.data, val); end
            end
            total++; if ((bus1.load & bus1.enable) | (bus3.load & bus3.enable)) begin
                bad++; $display("FAIL load_enable_overlap got=1 want=0 cycle=%0d", i); end
            if (i == 0) begin
                set_btn = 1'b0;
                databus_v = val;
            end
            if (i == 1) begin
                total++; if ({bus1.enable, bus1.load, ed1} !== 3'b100) begin
                    bad++; $display("FAIL settle1 got=%b want=100", {bus1.enable, bus1.load, ed1}); end
                total++; if (bus3.load !== 1'b1) begin bad++; $display("FAIL commit3_cycle2 got=%0d want=1", bus3.load); end
            end
            step(1);
        end
        total++; if (n1 !== 1) begin bad++; $display("FAIL load_len1 got=%0d want=1", n1); end
        total++; if (n3 !== 3) begin bad++; $display("FAIL load_len3 got=%0d want=3", n3); end
        total++; if ({t1, o1, t3, o3} !== {bcd, bcd}) begin
            bad++; $display("FAIL commit_readback got=%h want=%h", {t1, o1, t3, o3}, {bcd, bcd}); end
    endtask

    task automatic test_commit;
        pulse(0);
        total++; if ({ed1, bus1.enable, bus3.enable} !== 3'b100) begin
            bad++; $display("FAIL edit_entry got=%b want=100", {ed1, bus1.enable, bus3.enable}); end
        total++; if ({t1, o1} !== 8'h23) begin bad++; $display("FAIL edit_digits got=%h want=23", {t1, o1}); end
        pulse(1); pulse(1); pulse(1);
        total++; if ({t1, o1} !== 8'h26) begin bad++; $display("FAIL inc3_digits got=%h want=26", {t1, o1}); end
        total++; if (bus1.enable !== 1'b0) begin bad++; $display("FAIL edit_enable got=%0d want=0", bus1.enable); end
        do_commit(6'd26, 8'h26);
    endtask

    task automatic test_wrap;
        databus_v = 6'd60;
        step(2);
        total++; if ({t1, o1} !== 8'h60) begin bad++; $display("FAIL run_max got=%h want=60", {t1, o1}); end
        pulse(1);
        pulse(0);
        total++; if ({ed1, t1, o1} !== {1'b1, 8'h60}) begin
            bad++; $display("FAIL run_inc_ignored got=%h want=160", {ed1, t1, o1}); end
        pulse(1);
        total++; if ({t1, o1} !== 8'h01) begin bad++; $display("FAIL wrap_up got=%h want=01", {t1, o1}); end
        pulse(2);
        total++; if ({t1, o1} !== 8'h60) begin bad++; $display("FAIL wrap_down got=%h want=60", {t1, o1}); end
        pulse(2);
        total++; if ({t1, o1} !== 8'h59) begin bad++; $display("FAIL dec_59 got=%h want=59", {t1, o1}); end
        do_commit(6'd59, 8'h59);
    endtask

    task automatic test_same_cycle_and_hold;
        databus_v = 6'd15;
        step(2);
        pulse(0);
        inc_btn = 1'b1; dec_btn = 1'b1;
        step(1);
        inc_btn = 1'b0; dec_btn = 1'b0;
        step(1);
        total++; if ({t1, o1} !== 8'h15) begin bad++; $display("FAIL inc_dec_cancel got=%h want=15", {t1, o1}); end
        inc_btn = 1'b1;
        step(10);
        inc_btn = 1'b0;
        step(1);
        total++; if ({t1, o1} !== 8'h16) begin bad++; $display("FAIL inc_held got=%h want=16", {t1, o1}); end
        do_commit(6'd16, 8'h16);
    endtask

    task automatic test_commit_42;
        databus_v = 6'd42;
        step(2);
        pulse(0);
        do_commit(6'd42, 8'h42);
    endtask

    task automatic test_reset_mid;
        pulse(0);
        pulse(1);
        set_btn = 1'b1;
        step(2);
        total++; if (bus3.load !== 1'b1) begin bad++; $display("FAIL mid_load_pre got=%0d want=1", bus3.load); end
        #2 clear_n = 1'b0;
        #1;
        total++; if ({bus3.load, bus3.enable, ed3} !== 3'b000) begin
            bad++; $display("FAIL mid_reset_strobes got=%b want=000", {bus3.load, bus3.enable, ed3}); end
        total++; if ({bus3.data, t3, o3} !== {6'd1, 8'h01}) begin
            bad++; $display("FAIL mid_reset_values got=%h want=%h", {bus3.data, t3, o3}, {6'd1, 8'h01}); end
        set_btn = 1'b0;
        step(1);
        clear_n = 1'b1;
        databus_v = 6'd42;
        step(2);
        total++; if ({t1, o1, t3, o3} !== 16'h4242) begin
            bad++; $display("FAIL post_reset_digits got=%h want=4242", {t1, o1, t3, o3}); end
        total++; if ({bus3.load, bus3.enable} !== 2'b01) begin
            bad++; $display("FAIL no_retry got=%b want=01", {bus3.load, bus3.enable}); end
        databus_v = 6'd61;
        step(2);
        total++; if ({t3, o3} !== 8'h42) begin bad++; $display("FAIL reject_61 got=%h want=42", {t3, o3}); end
        databus_v = 6'd0;
        step(2);
        total++; if ({t3, o3} !== 8'h42) begin bad++; $display("FAIL reject_0 got=%h want=42", {t3, o3}); end
        databus_v = 6'd1;
        step(2);
        total++; if ({t3, o3} !== 8'h01) begin bad++; $display("FAIL accept_min got=%h want=01", {t3, o3}); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_commit;
        test_wrap;
        test_same_cycle_and_hold;
        test_commit_42;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
